// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared state encoding, sync/desync words and header field positions for the frame config loader
package cfg_loader_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, DATA, STROBE, HOLD} state_t;
    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
    localparam int COL_LSB   = 8;
    localparam int FRAME_LSB = 0;
    localparam int RSVD_LSB  = 16;
endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder: registered one-hot-or-zero strobe for the addressed column/frame
// Ports: CLK, resetn (async active-low), en (fire strobe next cycle), col/frame (address),
//        strobe (NumberOfCols*MaxFramesPerCol bits, bit col*MaxFramesPerCol+frame)
module frame_strobe_decoder #(
    parameter int NumberOfCols    = 4,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                                CLK,
    input  logic                                resetn,
    input  logic                                en,
    input  logic [7:0]                          col,
    input  logic [7:0]                          frame,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] strobe
);
    logic [NumberOfCols*MaxFramesPerCol-1:0] strobe_d, strobe_q;

    // Out-of-range addresses match no bit, so the vector stays zero for them.
    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < NumberOfCols; c++)
            for (int f = 0; f < MaxFramesPerCol; f++)
                strobe_d[c*MaxFramesPerCol+f] = en && col == 8'(c) && frame == 8'(f);
    end

    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) strobe_q <= '0;
        else         strobe_q <= strobe_d;

    assign strobe = strobe_q;
endmodule

// File: rtl/frame_config_loader.sv
// frame_config_loader: sync-word detecting loader that fills FrameData rows and pulses one FrameStrobe bit per frame
// Ports: CLK, resetn (async active-low), WriteData/WriteStrobe (word input, consumed when Ready),
//        Ready, FrameData (row r at [32r+31:32r]), FrameStrobe (col*MaxFramesPerCol+frame),
//        ConfigActive (between sync and desync), Error (sticky malformed-header flag)
module frame_config_loader
    import cfg_loader_pkg::*;
#(
    parameter int          NumberOfRows    = 4,
    parameter int          NumberOfCols    = 4,
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter logic [31:0] SyncWord        = SYNC_WORD,
    parameter logic [31:0] DesyncWord      = DESYNC_WORD
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             WriteData,
    input  logic                                    WriteStrobe,
    output logic                                    Ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                    ConfigActive,
    output logic                                    Error
);
    localparam int RW = NumberOfRows > 1 ? $clog2(NumberOfRows) : 1;

    if (FrameBitsPerRow != 32) begin : g_width_check
        $error("FrameBitsPerRow must be 32");
    end

    state_t                                  state_d, state_q;
    logic [RW-1:0]                           row_d, row_q;
    logic [7:0]                              col_d, col_q, frame_d, frame_q;
    logic                                    skip_d, skip_q, err_d, err_q, active_d, active_q;
    logic [NumberOfRows*FrameBitsPerRow-1:0] data_d, data_q;
    logic                                    accept, rsvd_zero, hdr_bad, last_row, strobe_en;

    assign Ready     = state_q == IDLE || state_q == HEADER || state_q == DATA;
    assign accept    = WriteStrobe && Ready;
    assign rsvd_zero = WriteData[31:RSVD_LSB] == '0;
    assign hdr_bad   = !rsvd_zero || WriteData[COL_LSB+:8] >= 8'(NumberOfCols)
                       || WriteData[FRAME_LSB+:8] >= 8'(MaxFramesPerCol);
    assign last_row  = row_q == RW'(NumberOfRows-1);
    // Fires on the last data word so the registered strobe lands in the STROBE cycle.
    assign strobe_en = state_q == DATA && accept && last_row && !skip_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        frame_d  = frame_q;
        skip_d   = skip_q;
        err_d    = err_q;
        active_d = active_q;
        data_d   = data_q;
        case (state_q)
            IDLE: if (accept && WriteData == SyncWord) begin
                state_d  = HEADER;
                active_d = 1'b1;
                err_d    = 1'b0;
            end
            HEADER: if (accept) begin
                if (WriteData == DesyncWord) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end else if (WriteData == SyncWord) begin
                    err_d = 1'b0;
                end else begin
                    err_d = err_q | hdr_bad;
                    // A bad address with a clean reserved field still swallows its data words.
                    if (rsvd_zero) begin
                        state_d = DATA;
                        col_d   = WriteData[COL_LSB+:8];
                        frame_d = WriteData[FRAME_LSB+:8];
                        row_d   = '0;
                        skip_d  = hdr_bad;
                    end
                end
            end
            DATA: if (accept) begin
                data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = WriteData;
                row_d = last_row ? '0 : row_q + RW'(1);
                if (last_row) state_d = skip_q ? HEADER : STROBE;
            end
            STROBE:  state_d = HOLD;
            HOLD:    state_d = HEADER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn)
        if (!resetn) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            frame_q  <= '0;
            skip_q   <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            skip_q   <= skip_d;
            err_q    <= err_d;
            active_q <= active_d;
            data_q   <= data_d;
        end

    frame_strobe_decoder #(
        .NumberOfCols   (NumberOfCols),
        .MaxFramesPerCol(MaxFramesPerCol)
    ) u_dec (
        .CLK   (CLK),
        .resetn(resetn),
        .en    (strobe_en),
        .col   (col_q),
        .frame (frame_q),
        .strobe(FrameStrobe)
    );

    assign FrameData    = data_q;
    assign ConfigActive = active_q;
    assign Error        = err_q;
endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader: scoreboard bench for frame_config_loader
module tb_frame_config_loader;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic         CLK = 1'b0;
    logic         resetn;
    logic [31:0]  WriteData;
    logic         WriteStrobe;
    logic         Ready;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         ConfigActive;
    logic         Error;

    typedef struct {
        logic [79:0]  strobe;
        logic [127:0] data;
    } exp_t;
    exp_t q[$];

    int compared   = 0;
    int mismatched = 0;
    int stalls;
    logic prev_hot = 1'b0;

    frame_config_loader dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .Ready       (Ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ConfigActive(ConfigActive),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] bit_at(input int idx);
        logic [79:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Holds WriteStrobe high; returns #1 after the accepting edge with the strobe still high.
    task automatic send(input logic [31:0] w, output int n);
        n = 0;
        WriteData   = w;
        WriteStrobe = 1'b1;
        forever begin
            @(negedge CLK);
            if (Ready) begin
                @(posedge CLK);
                #1;
                break;
            end
            n++;
            if (n > 20) begin
                chk("send_timeout", 128'(n), 128'(0));
                break;
            end
        end
    endtask

    task automatic sendw(input logic [31:0] w);
        int n;
        send(w, n);
    endtask

    task automatic idle(input int cycles);
        WriteStrobe = 1'b0;
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    // Monitor: every nonzero FrameStrobe must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (resetn && FrameStrobe != '0) begin
            if (prev_hot) chk("strobe_single_cycle", 128'(1), 128'(0));
            if (q.size() == 0) begin
                chk("unexpected_strobe", 128'(FrameStrobe), 128'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_strobe", 128'(FrameStrobe), 128'(e.strobe));
                chk("frame_data_at_strobe", FrameData, e.data);
            end
        end
        prev_hot = resetn && FrameStrobe != '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        WriteData   = '0;
        WriteStrobe = 1'b0;
        #12;
        chk("reset_ready", 128'(Ready), 128'(1));
        chk("reset_active", 128'(ConfigActive), 128'(0));
        chk("reset_error", 128'(Error), 128'(0));
        chk("reset_strobe", 128'(FrameStrobe), 128'(0));
        chk("reset_data", FrameData, 128'(0));
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK);
        #1;

        // Non-sync word ignored, sync enters config mode
        sendw(32'h1234_5678);
        chk("pre_sync_active", 128'(ConfigActive), 128'(0));
        sendw(SYNC);
        chk("sync_active", 128'(ConfigActive), 128'(1));
        chk("sync_error", 128'(Error), 128'(0));

        // Col 2 frame 3 -> bit 43
        q.push_back('{bit_at(43), {32'hA3, 32'hA2, 32'hA1, 32'hA0}});
        sendw(32'h0000_0203);
        for (int i = 0; i < 4; i++) sendw(32'hA0 + i);
        WriteStrobe = 1'b0;
        chk("strobe_cycle_ready", 128'(Ready), 128'(0));
        @(posedge CLK);
        #1;
        chk("hold_ready", 128'(Ready), 128'(0));
        chk("hold_strobe", 128'(FrameStrobe), 128'(0));
        chk("hold_data", FrameData, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        @(posedge CLK);
        #1;
        chk("ready_back", 128'(Ready), 128'(1));

        // Back-to-back frames with WriteStrobe held through STROBE/HOLD
        q.push_back('{bit_at(1), {32'hB3, 32'hB2, 32'hB1, 32'hB0}});
        q.push_back('{bit_at(62), {32'hC3, 32'hC2, 32'hC1, 32'hC0}});
        sendw(32'h0000_0001);
        for (int i = 0; i < 4; i++) sendw(32'hB0 + i);
        send(32'h0000_0302, stalls);
        chk("b2b_header_stalls", 128'(stalls), 128'(2));
        for (int i = 0; i < 4; i++) sendw(32'hC0 + i);
        idle(3);
        chk("b2b_queue_drained", 128'(q.size()), 128'(0));

        // Out-of-range header: data swallowed, no strobe, sticky error
        sendw(32'h0000_0514);
        chk("bad_hdr_error", 128'(Error), 128'(1));
        for (int i = 0; i < 4; i++) sendw(32'hD0 + i);
        idle(3);
        chk("bad_hdr_ready", 128'(Ready), 128'(1));
        chk("bad_hdr_error_sticky", 128'(Error), 128'(1));
        sendw(SYNC);
        chk("sync_clears_error", 128'(Error), 128'(0));
        sendw(32'h0001_0000);
        chk("rsvd_hdr_error", 128'(Error), 128'(1));
        sendw(SYNC);
        chk("sync_clears_error2", 128'(Error), 128'(0));

        // Desync then header-like words are discarded
        sendw(DESYNC);
        chk("desync_active", 128'(ConfigActive), 128'(0));
        sendw(32'h0000_0000);
        for (int i = 0; i < 4; i++) sendw(32'hE8 + i);
        idle(4);
        chk("idle_after_desync_active", 128'(ConfigActive), 128'(0));

        // Reset pulsed during STROBE; col 1 frame 5 -> bit 25
        sendw(SYNC);
        q.push_back('{bit_at(25), {32'hE3, 32'hE2, 32'hE1, 32'hE0}});
        sendw(32'h0000_0105);
        for (int i = 0; i < 4; i++) sendw(32'hE0 + i);
        WriteStrobe = 1'b0;
        @(negedge CLK);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rst_strobe", 128'(FrameStrobe), 128'(0));
        chk("async_rst_data", FrameData, 128'(0));
        chk("async_rst_active", 128'(ConfigActive), 128'(0));
        chk("async_rst_ready", 128'(Ready), 128'(1));
        #1;
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        sendw(32'h0000_0203);
        for (int i = 0; i < 4; i++) sendw(32'hF0 + i);
        idle(4);
        chk("post_rst_idle_active", 128'(ConfigActive), 128'(0));
        chk("post_rst_idle_data", FrameData, 128'(0));
        chk("final_queue_empty", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
